// File: rtl/imem_axil_rd_responder_pkg.sv
// ---------------------------------------------------------------------------
// imem_axil_rd_responder_pkg : shared bus types, RRESP codes, FSM states
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package imem_axil_rd_responder_pkg;

  typedef logic [31:0] MemAddrBus;
  typedef logic [63:0] MemDataBus;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned LAT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/imem_axil_rd_responder_lat_counter.sv
// ---------------------------------------------------------------------------
// lat_counter : 4-bit loadable down-counter, done while the count is zero
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lat_counter
  import imem_axil_rd_responder_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic [LAT_CNT_W-1:0] load_val_i,
  input  logic                 dec_i,
  output logic                 done_o
);

  logic [LAT_CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign done_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/imem_axil_rd_responder_reg.sv
// ---------------------------------------------------------------------------
// Reg : enable-gated register with synchronous clear, used for R buffers
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module Reg #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

`default_nettype wire

// File: rtl/imem_axil_rd_responder.sv
// ---------------------------------------------------------------------------
// imem_axil_rd_responder : AXI-lite read responder in front of the I-SRAM
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module imem_axil_rd_responder
  import imem_axil_rd_responder_pkg::*;
#(
  parameter MemAddrBus   BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ARVALID_i,
  input  logic [31:0]                    ARADDR_i,
  output logic                           ARREADY_o,
  output logic                           RVALID_o,
  input  logic                           RREADY_i,
  output logic [63:0]                    RDATA_o,
  output logic [1:0]                     RRESP_o,
  output logic                           mem_ren_o,
  output logic [$clog2(DEPTH_WORDS)-1:0] mem_raddr_o,
  input  logic [63:0]                    mem_rdata_i
);

  localparam int unsigned          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [32:0]          WIN_BYTES = 33'(DEPTH_WORDS) * 33'd8;
  localparam logic [LAT_CNT_W-1:0] LOAD_VAL  = LAT_CNT_W'(LATENCY - 2);

  state_e    state_q, state_d;
  logic      ready_en_q;
  logic      first_q;
  logic      arready_w;
  logic      rvalid_w;
  logic      hs_w;
  logic      cnt_done_w;
  MemAddrBus offset_w;
  logic      in_range_w;
  logic [1:0] rresp_w;
  MemDataBus rdata_w;

  // Wrapping subtraction makes addresses below BASE_ADDR land far out of range.
  assign offset_w    = ARADDR_i - BASE_ADDR;
  assign in_range_w  = ({1'b0, offset_w} < WIN_BYTES);
  assign mem_raddr_o = offset_w[IDX_W+2:3];

  assign hs_w      = ARVALID_i & arready_w;
  assign mem_ren_o = hs_w & in_range_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ready_en_q <= 1'b0;
      first_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
      first_q    <= hs_w;
    end
  end

  always_comb begin
    state_d   = state_q;
    arready_w = 1'b0;
    rvalid_w  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        arready_w = ready_en_q;
        if (ARVALID_i && ready_en_q) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_done_w) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        rvalid_w = 1'b1;
        if (RREADY_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  lat_counter u_lat_counter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (hs_w),
    .load_val_i (LOAD_VAL),
    .dec_i      (state_q == ST_WAIT),
    .done_o     (cnt_done_w)
  );

  Reg #(.WIDTH(2)) u_rresp_buf (
    .clk  (clk),
    .rst  (rst),
    .en_i (hs_w),
    .d_i  (in_range_w ? RESP_OKAY : RESP_DECERR),
    .q_o  (rresp_w)
  );

  // SRAM data is only valid in the first WAIT cycle; DECERR forces zero data.
  Reg #(.WIDTH(64)) u_rdata_buf (
    .clk  (clk),
    .rst  (rst),
    .en_i (first_q),
    .d_i  ((rresp_w == RESP_DECERR) ? 64'd0 : mem_rdata_i),
    .q_o  (rdata_w)
  );

  assign ARREADY_o = arready_w;
  assign RVALID_o  = rvalid_w;
  assign RDATA_o   = rdata_w;
  assign RRESP_o   = rresp_w;

endmodule

`default_nettype wire

// File: tb/tb_imem_axil_rd_responder.sv
// Bench for imem_axil_rd_responder: two instances (LATENCY 2 and 5), SRAM models,
// directed plus randomized reads, queue scoreboard with an independent R monitor.
`default_nettype none

module tb_imem_axil_rd_responder;

  localparam int unsigned DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          LAT0  = 2;
  localparam int          LAT1  = 5;
  localparam int          BOUND = 64;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arvalid   [2];
  logic [31:0] araddr    [2];
  logic        arready   [2];
  logic        rvalid    [2];
  logic        rready    [2];
  logic [63:0] rdata     [2];
  logic [1:0]  rresp     [2];
  logic        mem_ren   [2];
  logic [11:0] mem_raddr [2];
  logic [63:0] mem_rdata [2];

  logic [63:0] sram [DEPTH];
  beat_t exp_q0[$];
  beat_t exp_q1[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_rhs[2];
  int last_k  = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imem_axil_rd_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(LAT0)) dut0 (
    .clk(clk), .rst(rst),
    .ARVALID_i(arvalid[0]), .ARADDR_i(araddr[0]), .ARREADY_o(arready[0]),
    .RVALID_o(rvalid[0]), .RREADY_i(rready[0]), .RDATA_o(rdata[0]), .RRESP_o(rresp[0]),
    .mem_ren_o(mem_ren[0]), .mem_raddr_o(mem_raddr[0]), .mem_rdata_i(mem_rdata[0])
  );

  imem_axil_rd_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(LAT1)) dut1 (
    .clk(clk), .rst(rst),
    .ARVALID_i(arvalid[1]), .ARADDR_i(araddr[1]), .ARREADY_o(arready[1]),
    .RVALID_o(rvalid[1]), .RREADY_i(rready[1]), .RDATA_o(rdata[1]), .RRESP_o(rresp[1]),
    .mem_ren_o(mem_ren[1]), .mem_raddr_o(mem_raddr[1]), .mem_rdata_i(mem_rdata[1])
  );

  // One-cycle SRAM; garbage when not enabled so a mistimed capture shows up.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      mem_rdata[k] <= mem_ren[k] ? sram[mem_raddr[k]] : {$urandom, $urandom};
    end
  end

  function automatic beat_t ref_read(input logic [31:0] addr);
    logic [31:0] off;
    beat_t b;
    off = addr - BASE;
    if (off < 32'(DEPTH * 8)) begin
      b.data = sram[int'(off >> 3)];
      b.resp = 2'b00;
    end else begin
      b.data = 64'd0;
      b.resp = 2'b11;
    end
    return b;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: no response within %0d cycles (t=%0t)", name, BOUND, $time);
  endtask

  // Scoreboard monitor: pops one expected beat per R handshake.
  always @(negedge clk) begin
    beat_t e;
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        if (rvalid[k] && rready[k]) begin
          if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_beat dut%0d: got data %h resp %b, expected none", k, rdata[k], rresp[k]);
          end else begin
            if (k == 0) e = exp_q0.pop_front();
            else        e = exp_q1.pop_front();
            chk($sformatf("rdata dut%0d", k), rdata[k], e.data);
            chk($sformatf("rresp dut%0d", k), 64'(rresp[k]), 64'(e.resp));
          end
        end
      end
    end
  end

  task automatic do_read(input int k, input logic [31:0] addr, input int stall, input int gap);
    int t, c0, lat;
    beat_t e;
    logic [63:0] hd;
    logic [1:0]  hr;
    lat = (k == 0) ? LAT0 : LAT1;
    e   = ref_read(addr);
    repeat (gap) @(posedge clk);
    @(posedge clk); #1;
    araddr[k]  = addr;
    arvalid[k] = 1'b1;
    rready[k]  = (stall == 0);
    @(negedge clk);
    t = 0;
    while (!arready[k] && t < BOUND) begin
      @(negedge clk);
      t++;
    end
    if (!arready[k]) begin
      timeout("ar_accept");
      arvalid[k] = 1'b0;
      return;
    end
    c0 = cyc;
    if (gap == 0 && last_k == k) chk("next_ar_cycle", 64'(c0), 64'(last_rhs[k] + 1));
    chk("mem_ren", 64'(mem_ren[k]), 64'(e.resp == 2'b00));
    if (e.resp == 2'b00) chk("mem_raddr", 64'(mem_raddr[k]), 64'((addr - BASE) >> 3));
    chk("rvalid_at_ar", 64'(rvalid[k]), 64'd0);
    if (k == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
    @(posedge clk); #1;
    arvalid[k] = 1'b0;
    araddr[k]  = $urandom;
    @(negedge clk);
    chk("arready_busy", 64'(arready[k]), 64'd0);
    t = 1;
    while (!rvalid[k] && t < BOUND) begin
      @(negedge clk);
      t++;
    end
    if (!rvalid[k]) begin
      timeout("rvalid");
      return;
    end
    chk("latency", 64'(cyc - c0), 64'(lat));
    hd = rdata[k];
    hr = rresp[k];
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("hold_rvalid", 64'(rvalid[k]), 64'd1);
      chk("hold_rdata", rdata[k], hd);
      chk("hold_rresp", 64'(rresp[k]), 64'(hr));
      chk("hold_arready", 64'(arready[k]), 64'd0);
    end
    if (stall > 0) begin
      @(posedge clk); #1;
      rready[k] = 1'b1;
      @(negedge clk);
    end
    last_rhs[k] = cyc;
    last_k      = k;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom % 5)
      0:       return BASE + 32'(($urandom % DEPTH) * 8) + 32'($urandom % 8);
      1:       return BASE - 32'(8 * (1 + $urandom % 16)) + 32'($urandom % 8);
      2:       return BASE + 32'(DEPTH * 8) + 32'($urandom % 4096);
      3:       return BASE + 32'((DEPTH - 1) * 8) + 32'($urandom % 8);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bit seen;
    for (int i = 0; i < int'(DEPTH); i++) sram[i] = {$urandom, $urandom};
    for (int k = 0; k < 2; k++) begin
      arvalid[k]  = 1'b0;
      araddr[k]   = 32'd0;
      rready[k]   = 1'b0;
      last_rhs[k] = -1;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_arready", 64'(arready[k]), 64'd0);
      chk("rst_rvalid", 64'(rvalid[k]), 64'd0);
      chk("rst_rdata", rdata[k], 64'd0);
      chk("rst_rresp", 64'(rresp[k]), 64'd0);
      chk("rst_mem_ren", 64'(mem_ren[k]), 64'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("arready_after_rst_fall", 64'(arready[0]), 64'd0);
    @(negedge clk);
    chk("arready_rise", 64'(arready[0]), 64'd1);

    // Directed reads
    do_read(0, BASE, 0, 0);
    do_read(0, BASE + 32'h0C, 0, 0);
    do_read(0, 32'h7FFF_FFF8, 0, 0);
    do_read(0, 32'h8000_8000, 0, 0);
    do_read(0, BASE + 32'h7FF8, 0, 0);
    do_read(0, BASE + 32'h8, 5, 0);
    do_read(0, BASE + 32'h10, 0, 0);
    do_read(1, BASE + 32'h18, 0, 0);
    do_read(1, BASE + 32'h20, 0, 0);
    do_read(1, 32'h8000_8000, 3, 0);

    // Randomized reads
    for (int i = 0; i < 80; i++) begin
      do_read(int'($urandom % 2), rand_addr(),
              ($urandom % 2 == 0) ? 0 : int'($urandom_range(1, 4)),
              int'($urandom % 3));
    end

    // Reset while the LATENCY=5 instance is in WAIT
    @(posedge clk); #1;
    araddr[1]  = BASE + 32'h28;
    arvalid[1] = 1'b1;
    rready[1]  = 1'b1;
    @(negedge clk);
    t = 0;
    while (!arready[1] && t < BOUND) begin
      @(negedge clk);
      t++;
    end
    if (!arready[1]) timeout("ar_accept_abort");
    @(posedge clk); #1;
    arvalid[1] = 1'b0;
    rst        = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("abort_arready", 64'(arready[1]), 64'd0);
    chk("abort_rvalid", 64'(rvalid[1]), 64'd0);
    chk("abort_rdata", rdata[1], 64'd0);
    chk("abort_rresp", 64'(rresp[1]), 64'd0);
    chk("abort_mem_ren", 64'(mem_ren[1]), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_arready_low", 64'(arready[1]), 64'd0);
    seen = 1'b0;
    @(negedge clk);
    chk("abort_arready_back", 64'(arready[1]), 64'd1);
    repeat (10) begin
      @(negedge clk);
      if (rvalid[1]) seen = 1'b1;
    end
    chk("abort_no_beat", 64'(seen), 64'd0);
    last_k = -1;

    do_read(1, BASE + 32'h30, 0, 0);
    do_read(0, BASE + 32'h38, 2, 1);

    repeat (4) @(negedge clk);
    chk("queue0_drained", 64'(exp_q0.size()), 64'd0);
    chk("queue1_drained", 64'(exp_q1.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imem_axil_rd_responder.md
# imem_axil_rd_responder

AXI-lite read-channel responder serving instruction fetches from the IFU. It accepts one read address at a time and reads a 64-bit word from a synchronous single-port instruction SRAM. After a programmable latency it returns the word with an OKAY or DECERR response. It sits between the IFU's AR/R master port and the instruction SRAM macro. It also serves as the stall-injection point for front-end testing.

## Interface
- `BASE_ADDR`, default 32'h8000_0000: byte address of SRAM word 0.
- `DEPTH_WORDS`, default 4096: number of 64-bit SRAM words; must be a power of two.
- `LATENCY`, default 2: cycles from the AR handshake cycle to the first RVALID cycle; legal range 2..15.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: reset, synchronous and active-high.
- `ARVALID` in 1: read address valid.
- `ARADDR` in `MemAddrBus`: byte address.
- `ARREADY` out 1: responder can accept an address.
- `RVALID` out 1: read data valid.
- `RREADY` in 1: master accepts data.
- `RDATA` out `MemDataBus`: full 64-bit aligned word.
- `RRESP` out 2: 2'b00 OKAY, 2'b11 DECERR.
- `mem_ren` out 1: SRAM read enable.
- `mem_raddr` out log2(DEPTH_WORDS): SRAM word index.
- `mem_rdata` in 64: SRAM data, valid the cycle after `mem_ren`.

## Operation
- FSM states:
  - IDLE: ARREADY=1. On ARVALID, go to WAIT; if the address is in range, mem_ren=1 and mem_raddr=word index; load the counter with LATENCY-2.
  - WAIT: ARREADY=0. In the first WAIT cycle, capture `mem_rdata` into the data buffer for an OKAY, or load 0 for a DECERR. Decrement the counter each cycle; at 0, go to RESP.
  - RESP: RVALID=1 with RDATA/RRESP from the buffers. On RREADY, go to IDLE.
- `mem_ren` is combinational: ARVALID & ARREADY & in_range. `mem_raddr` is driven from the same combinational decode.
- Address decode:
  - offset = ARADDR − BASE_ADDR, computed at `MemAddrBus` width with wrap.
  - in_range = offset < DEPTH_WORDS*8.
  - Word index = offset[log2(DEPTH_WORDS)+2:3].
  - ARADDR[2:0] is ignored; the master selects the 32-bit half.
- Out of range: no SRAM access; RDATA=0; RRESP=2'b11.
- RDATA and RRESP are held stable while RVALID=1 && !RREADY.
- Only one transaction is outstanding. ARVALID in WAIT or RESP is not accepted; the master must hold it.
- There is no AR acceptance in the same cycle as the R handshake. The next AR can be accepted one cycle after the R handshake.

## Timing
- Reset values: ARREADY=0, RVALID=0, RDATA=0, RRESP=0, mem_ren=0; state=IDLE.
- ARREADY is 0 while rst is high and rises in the first cycle after rst deasserts.
- AR handshake in cycle C. mem_rdata is valid in C+1. RVALID is first high in C+LATENCY.
- Throughput with RREADY tied 1: one word per LATENCY+1 cycles.
- Backpressure: RVALID stays high with stable data until an RREADY cycle. It drops in the cycle after the handshake.
- rst asserted mid-transaction (WAIT or RESP): the transaction is discarded and all outputs return to reset values at the next edge. No R beat is emitted for the aborted request.
- ARADDR may change when ARVALID=0. The value sampled on the handshake edge is the only one used.

## Structure
- The shared defines header holds `MemAddrBus`, `MemDataBus`, the RRESP encodings (RESP_OKAY, RESP_DECERR), and the FSM state encodings.
- The latency counter is a natural sub-module: `lat_counter`, a down-counter with load and done outputs, 4 bits wide.
- The `Reg` primitive is used for the RDATA/RRESP buffers.
- The SRAM is external. The bench supplies a behavioral model with one-cycle read latency.

## Test plan
- Reset, then ARADDR=0x8000_0000 with ARVALID pulsed, LATENCY=2, RREADY=1:
  - mem_ren=1 with mem_raddr=0 in cycle C.
  - RVALID in C+2 with RDATA=SRAM[0] and RRESP=00.
- ARADDR=0x8000_000C: mem_raddr=1; RDATA is the full word SRAM[1], low bits ignored.
- ARADDR=0x7FFF_FFF8, then 0x8000_8000 with DEPTH_WORDS=4096:
  - No mem_ren.
  - RDATA=0, RRESP=11 for both.
- RREADY held 0 for 5 cycles after RVALID: RVALID, RDATA and RRESP stay constant. ARREADY=0 throughout. After RREADY=1, ARREADY=1 the cycle after the handshake.
- LATENCY=5 with back-to-back ARVALID and RREADY=1: RVALID at C+5, and the next AR is accepted at C+6.
- rst asserted in the WAIT cycle:
  - All outputs are 0 at the next edge.
  - No RVALID appears afterward.
  - ARREADY returns 1 one cycle after rst falls.
